// File: rtl/relu_out_packer.sv
// Packs a stream of activation bytes into little-endian 32-bit words with
// per-lane keep and frame-last marking, buffered through a 2-entry output FIFO.
module relu_out_packer #(
    parameter int FRAME_BYTES = 1024,
    parameter int CNT_W       = 16
) (
    input  logic        ap_clk,
    input  logic        ap_rst_n,
    input  logic [7:0]  reluRes_V_V_TDATA,
    input  logic        reluRes_V_V_TVALID,
    output logic        reluRes_V_V_TREADY,
    output logic [31:0] OutDMA_V_V_TDATA,
    output logic [3:0]  OutDMA_V_V_TKEEP,
    output logic        OutDMA_V_V_TLAST,
    output logic        OutDMA_V_V_TVALID,
    input  logic        OutDMA_V_V_TREADY,
    output logic        frame_done
);
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(FRAME_BYTES - 1);

    logic [CNT_W-1:0] byte_cnt_reg;
    logic [1:0]       lane_reg;
    logic [23:0]      pack_reg;
    logic             ready_en_reg;
    logic [1:0]       count_reg;
    logic             wr_ptr_reg;
    logic             rd_ptr_reg;
    logic             frame_done_reg;

    logic        frame_end;
    logic        word_end;
    logic        in_fire;
    logic        push;
    logic        pop;
    logic [31:0] word_data;
    logic [3:0]  word_keep;

    assign frame_end = (byte_cnt_reg == LAST_IDX);
    assign word_end  = (lane_reg == 2'd3) || frame_end;

    // A byte that only fills the packing register never needs FIFO space.
    assign reluRes_V_V_TREADY = ready_en_reg && (!word_end || (count_reg < 2'd2));
    assign in_fire = reluRes_V_V_TVALID && reluRes_V_V_TREADY;
    assign push    = in_fire && word_end;
    assign pop     = OutDMA_V_V_TVALID && OutDMA_V_V_TREADY;

    // Lanes above the current one are still zero in pack_reg, so OR-in is safe.
    assign word_data = {8'd0, pack_reg} | ({24'd0, reluRes_V_V_TDATA} << {lane_reg, 3'b000});

    always_comb begin
        word_keep = 4'b0001;
        case (lane_reg)
            2'd0:    word_keep = 4'b0001;
            2'd1:    word_keep = 4'b0011;
            2'd2:    word_keep = 4'b0111;
            default: word_keep = 4'b1111;
        endcase
    end

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            byte_cnt_reg   <= '0;
            lane_reg       <= 2'd0;
            pack_reg       <= 24'd0;
            ready_en_reg   <= 1'b0;
            count_reg      <= 2'd0;
            wr_ptr_reg     <= 1'b0;
            rd_ptr_reg     <= 1'b0;
            frame_done_reg <= 1'b0;
        end else begin
            ready_en_reg   <= 1'b1;
            frame_done_reg <= pop && OutDMA_V_V_TLAST;
            if (in_fire) begin
                byte_cnt_reg <= frame_end ? '0 : byte_cnt_reg + CNT_W'(1);
                if (word_end) begin
                    lane_reg <= 2'd0;
                    pack_reg <= 24'd0;
                end else begin
                    lane_reg <= lane_reg + 2'd1;
                    pack_reg <= word_data[23:0];
                end
            end
            if (push) wr_ptr_reg <= ~wr_ptr_reg;
            if (pop)  rd_ptr_reg <= ~rd_ptr_reg;
            case ({push, pop})
                2'b10:   count_reg <= count_reg + 2'd1;
                2'b01:   count_reg <= count_reg - 2'd1;
                default: count_reg <= count_reg;
            endcase
        end
    end

    for (genvar gi = 0; gi < 2; gi++) begin : g_fifo
        logic [31:0] data_reg;
        logic [3:0]  keep_reg;
        logic        last_reg;

        always_ff @(posedge ap_clk or negedge ap_rst_n) begin
            if (!ap_rst_n) begin
                data_reg <= 32'd0;
                keep_reg <= 4'd0;
                last_reg <= 1'b0;
            end else if (push && (wr_ptr_reg == 1'(gi))) begin
                data_reg <= word_data;
                keep_reg <= word_keep;
                last_reg <= frame_end;
            end
        end
    end

    assign OutDMA_V_V_TDATA  = rd_ptr_reg ? g_fifo[1].data_reg : g_fifo[0].data_reg;
    assign OutDMA_V_V_TKEEP  = rd_ptr_reg ? g_fifo[1].keep_reg : g_fifo[0].keep_reg;
    assign OutDMA_V_V_TLAST  = rd_ptr_reg ? g_fifo[1].last_reg : g_fifo[0].last_reg;
    assign OutDMA_V_V_TVALID = (count_reg != 2'd0);
    assign frame_done        = frame_done_reg;

endmodule

// File: tb/tb_relu_out_packer.sv
// Bench for relu_out_packer: four instances (FRAME_BYTES 8, 6, 1, 10) checked
// every cycle against a word-level reference model plus literal expectations.
module tb_relu_out_packer;
    logic clk = 1'b0;
    logic rst_n = 1'b0;

    logic [7:0]  in_data   [4];
    logic        in_valid  [4];
    logic        in_ready  [4];
    logic [31:0] out_data  [4];
    logic [3:0]  out_keep  [4];
    logic        out_last  [4];
    logic        out_valid [4];
    logic        out_ready [4];
    logic        frame_done [4];

    int checks = 0;
    int errors = 0;

    function automatic int fb_of(input int i);
        case (i)
            0:       return 8;
            1:       return 6;
            2:       return 1;
            default: return 10;
        endcase
    endfunction

    always #5 clk = ~clk;

    for (genvar gi = 0; gi < 4; gi++) begin : g_dut
        relu_out_packer #(.FRAME_BYTES(fb_of(gi)), .CNT_W(16)) u_dut (
            .ap_clk             (clk),
            .ap_rst_n           (rst_n),
            .reluRes_V_V_TDATA  (in_data[gi]),
            .reluRes_V_V_TVALID (in_valid[gi]),
            .reluRes_V_V_TREADY (in_ready[gi]),
            .OutDMA_V_V_TDATA   (out_data[gi]),
            .OutDMA_V_V_TKEEP   (out_keep[gi]),
            .OutDMA_V_V_TLAST   (out_last[gi]),
            .OutDMA_V_V_TVALID  (out_valid[gi]),
            .OutDMA_V_V_TREADY  (out_ready[gi]),
            .frame_done         (frame_done[gi])
        );
    end

    task automatic chk(input string name, input int i, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s inst%0d: got %0h expected %0h", name, i, act, exp);
        end
    endtask

    // Reference model: expected words as {last, keep, data}
    logic [36:0] mf [4][4];
    int          mhead [4];
    int          mcount [4];
    logic [31:0] cur_word [4];
    int          cur_n [4];
    int          fpos [4];
    bit          fd_exp [4];
    bit          armed = 1'b0;

    logic [36:0] got [4][16];
    int          got_n [4];
    int          wcount [4];
    int          fd_cnt [4];

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) armed <= 1'b0;
        else        armed <= 1'b1;
    end

    always @(negedge clk) begin
        logic        er;
        logic [36:0] hd;
        int          fb;
        for (int i = 0; i < 4; i++) begin
            if (!rst_n) begin
                chk("rst_in_ready", i, in_ready[i], 0);
                chk("rst_out_valid", i, out_valid[i], 0);
                chk("rst_out_data", i, out_data[i], 0);
                chk("rst_out_keep", i, out_keep[i], 0);
                chk("rst_out_last", i, out_last[i], 0);
                chk("rst_frame_done", i, frame_done[i], 0);
                mhead[i] = 0; mcount[i] = 0; cur_word[i] = 0;
                cur_n[i] = 0; fpos[i] = 0; fd_exp[i] = 0;
            end else begin
                fb = fb_of(i);
                er = armed && ((cur_n[i] != 3 && fpos[i] != fb - 1) || mcount[i] < 2);
                hd = mf[i][mhead[i]];
                chk("in_ready", i, in_ready[i], er);
                chk("out_valid", i, out_valid[i], mcount[i] != 0);
                if (mcount[i] != 0) begin
                    chk("out_data", i, out_data[i], hd[31:0]);
                    chk("out_keep", i, out_keep[i], hd[35:32]);
                    chk("out_last", i, out_last[i], hd[36]);
                end
                chk("frame_done", i, frame_done[i], fd_exp[i]);
                if (frame_done[i]) fd_cnt[i]++;
                fd_exp[i] = 1'b0;
                if (mcount[i] != 0 && out_ready[i]) begin
                    if (got_n[i] < 16) begin
                        got[i][got_n[i]] = hd;
                        got_n[i]++;
                    end
                    wcount[i]++;
                    fd_exp[i] = hd[36];
                    mhead[i] = (mhead[i] + 1) % 4;
                    mcount[i]--;
                end
                if (in_valid[i] && er) begin
                    cur_word[i] = cur_word[i] | (32'(in_data[i]) << (8 * cur_n[i]));
                    cur_n[i]++;
                    fpos[i]++;
                    if (cur_n[i] == 4 || fpos[i] == fb) begin
                        mf[i][(mhead[i] + mcount[i]) % 4] = {fpos[i] == fb, 4'((1 << cur_n[i]) - 1), cur_word[i]};
                        mcount[i]++;
                        cur_word[i] = 0;
                        cur_n[i] = 0;
                        if (fpos[i] == fb) fpos[i] = 0;
                    end
                end
            end
        end
    end

    // Offer n consecutive bytes; returns how many were accepted within budget cycles.
    task automatic stream(input int i, input logic [7:0] first, input int n, input int budget, output int accepted);
        int k = 0;
        int cyc = 0;
        while (k < n && cyc < budget) begin
            in_valid[i] = 1'b1;
            in_data[i]  = 8'(first + k);
            @(negedge clk);
            if (in_ready[i]) k++;
            @(posedge clk); #1;
            cyc++;
        end
        in_valid[i] = 1'b0;
        accepted = k;
    endtask

    task automatic wait_idle(input int budget);
        int c = 0;
        while ((mcount[0] + mcount[1] + mcount[2] + mcount[3]) != 0 && c < budget) begin
            @(negedge clk);
            c++;
        end
        chk("drain_timeout", 0, (c < budget), 1);
        repeat (3) @(negedge clk);
        @(posedge clk); #1;
    endtask

    task automatic clear_logs();
        for (int i = 0; i < 4; i++) got_n[i] = 0;
    endtask

    initial begin
        #1_500_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int acc;
        int fd0;
        int w0;
        int k;
        int cyc;
        for (int i = 0; i < 4; i++) begin
            in_valid[i] = 1'b0; in_data[i] = 8'd0; out_ready[i] = 1'b1;
            got_n[i] = 0; wcount[i] = 0; fd_cnt[i] = 0;
        end

        // Reset and release: ready only after the first edge with reset high
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("ready_before_edge", 0, in_ready[0], 0);
        @(negedge clk);
        chk("ready_after_edge", 0, in_ready[0], 1);
        @(posedge clk); #1;

        // FRAME_BYTES=8, 0x01..0x08, full throughput
        clear_logs();
        fd0 = fd_cnt[0];
        stream(0, 8'h01, 8, 8, acc);
        chk("no_stall_accept", 0, acc, 8);
        wait_idle(50);
        chk("f8_words", 0, got_n[0], 2);
        chk("f8_w0", 0, got[0][0], {1'b0, 4'hF, 32'h04030201});
        chk("f8_w1", 0, got[0][1], {1'b1, 4'hF, 32'h08070605});
        chk("f8_frame_done", 0, fd_cnt[0] - fd0, 1);

        // Back-pressure: 12 bytes offered with output stalled
        clear_logs();
        out_ready[0] = 1'b0;
        stream(0, 8'h21, 12, 20, acc);
        chk("bp_accepted", 0, acc, 11);
        @(negedge clk);
        chk("bp_in_ready", 0, in_ready[0], 0);
        chk("bp_out_valid", 0, out_valid[0], 1);
        chk("bp_head_held", 0, out_data[0], 32'h24232221);
        @(posedge clk); #1;
        out_ready[0] = 1'b1;
        stream(0, 8'h2C, 1, 20, acc);
        chk("bp_last_byte", 0, acc, 1);
        wait_idle(50);
        chk("bp_words", 0, got_n[0], 3);
        chk("bp_w0", 0, got[0][0], {1'b0, 4'hF, 32'h24232221});
        chk("bp_w1", 0, got[0][1], {1'b1, 4'hF, 32'h28272625});
        chk("bp_w2", 0, got[0][2], {1'b0, 4'hF, 32'h2C2B2A29});

        // Reset mid-frame with a word held in instance 1
        clear_logs();
        out_ready[1] = 1'b0;
        stream(1, 8'hC1, 4, 10, acc);
        stream(0, 8'h31, 3, 10, acc);
        @(negedge clk);
        chk("pre_rst_valid", 1, out_valid[1], 1);
        @(posedge clk); #3;
        rst_n = 1'b0;
        #1;
        chk("arst_out_valid", 1, out_valid[1], 0);
        chk("arst_out_data", 1, out_data[1], 0);
        chk("arst_out_keep", 1, out_keep[1], 0);
        chk("arst_out_last", 1, out_last[1], 0);
        chk("arst_in_ready", 1, in_ready[1], 0);
        chk("arst_in_ready", 0, in_ready[0], 0);
        chk("arst_frame_done", 1, frame_done[1], 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        out_ready[1] = 1'b1;
        @(posedge clk); #1;
        stream(0, 8'h11, 8, 8, acc);
        chk("post_rst_accept", 0, acc, 8);
        wait_idle(50);
        chk("post_rst_words", 0, got_n[0], 2);
        chk("post_rst_w0", 0, got[0][0], {1'b0, 4'hF, 32'h14131211});
        chk("post_rst_w1", 0, got[0][1], {1'b1, 4'hF, 32'h18171615});
        chk("rst_discard", 1, got_n[1], 0);

        // FRAME_BYTES=6: partial last word, next frame restarts at lane 0
        clear_logs();
        stream(1, 8'hA1, 6, 6, acc);
        stream(1, 8'hB1, 6, 6, acc);
        wait_idle(50);
        chk("f6_words", 1, got_n[1], 4);
        chk("f6_w0", 1, got[1][0], {1'b0, 4'hF, 32'hA4A3A2A1});
        chk("f6_w1", 1, got[1][1], {1'b1, 4'h3, 32'h0000A6A5});
        chk("f6_w2", 1, got[1][2], {1'b0, 4'hF, 32'hB4B3B2B1});
        chk("f6_w3", 1, got[1][3], {1'b1, 4'h3, 32'h0000B6B5});

        // FRAME_BYTES=1: every byte is its own last word
        clear_logs();
        fd0 = fd_cnt[2];
        stream(2, 8'h55, 1, 10, acc);
        stream(2, 8'h66, 1, 10, acc);
        wait_idle(50);
        chk("f1_w0", 2, got[2][0], {1'b1, 4'h1, 32'h00000055});
        chk("f1_w1", 2, got[2][1], {1'b1, 4'h1, 32'h00000066});
        chk("f1_frame_done", 2, fd_cnt[2] - fd0, 2);

        // FRAME_BYTES=10: random handshakes over 1000 frames
        fd0 = fd_cnt[3];
        w0  = wcount[3];
        k = 0;
        cyc = 0;
        while (k < 10000 && cyc < 60000) begin
            in_valid[3]  = ($urandom_range(0, 3) != 0);
            in_data[3]   = 8'($urandom);
            out_ready[3] = ($urandom_range(0, 2) != 0);
            @(negedge clk);
            if (in_valid[3] && in_ready[3]) k++;
            @(posedge clk); #1;
            cyc++;
        end
        in_valid[3]  = 1'b0;
        out_ready[3] = 1'b1;
        wait_idle(100);
        chk("rand_bytes", 3, k, 10000);
        chk("rand_words", 3, wcount[3] - w0, 3000);
        chk("rand_frame_done", 3, fd_cnt[3] - fd0, 1000);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
